// File: rtl/issue_buffer_if.sv
// Issue buffer bus: decode input, register-file read, ROB/rename write and RS/LSB dispatch.
// The issue buffer sits on the slave modport; the surrounding pipeline uses master.
interface issue_buffer_if #(
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  logic              id_valid;
  logic              id_ready;
  logic [OP_W-1:0]   id_op;
  logic [REG_W-1:0]  id_rs1;
  logic [REG_W-1:0]  id_rs2;
  logic [REG_W-1:0]  id_rd;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc;

  logic [REG_W-1:0]  rf_rs1_addr;
  logic [REG_W-1:0]  rf_rs2_addr;
  logic [DATA_W-1:0] rf_stat1;
  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_stat2;
  logic [DATA_W-1:0] rf_data2;

  logic              rob_full;
  logic [TAG_W-1:0]  rob_tag;
  logic              rob_valid;
  logic [OP_W-1:0]   rob_op;
  logic [DATA_W-1:0] rob_pc;
  logic [DATA_W-1:0] rob_imm;
  logic [REG_W-1:0]  rob_rd;

  logic              ren_we;
  logic [REG_W-1:0]  ren_addr;
  logic [TAG_W-1:0]  ren_tag;

  logic              rs_full;
  logic              lsb_full;
  logic              rs_valid;
  logic              lsb_valid;

  logic [OP_W-1:0]   q_op;
  logic [DATA_W-1:0] q_stat1;
  logic [DATA_W-1:0] q_data1;
  logic [DATA_W-1:0] q_stat2;
  logic [DATA_W-1:0] q_data2;
  logic [DATA_W-1:0] q_imm;
  logic [TAG_W-1:0]  q_tag;

  modport slave (
    input  id_valid, id_op, id_rs1, id_rs2, id_rd, id_imm, id_pc,
    input  rf_stat1, rf_data1, rf_stat2, rf_data2,
    input  rob_full, rob_tag, rs_full, lsb_full,
    output id_ready, rf_rs1_addr, rf_rs2_addr,
    output rob_valid, rob_op, rob_pc, rob_imm, rob_rd,
    output ren_we, ren_addr, ren_tag,
    output rs_valid, lsb_valid,
    output q_op, q_stat1, q_data1, q_stat2, q_data2, q_imm, q_tag
  );

  modport master (
    output id_valid, id_op, id_rs1, id_rs2, id_rd, id_imm, id_pc,
    output rf_stat1, rf_data1, rf_stat2, rf_data2,
    output rob_full, rob_tag, rs_full, lsb_full,
    input  id_ready, rf_rs1_addr, rf_rs2_addr,
    input  rob_valid, rob_op, rob_pc, rob_imm, rob_rd,
    input  ren_we, ren_addr, ren_tag,
    input  rs_valid, lsb_valid,
    input  q_op, q_stat1, q_data1, q_stat2, q_data2, q_imm, q_tag
  );
endinterface

// File: rtl/issue_buffer.sv
// In-order issue FIFO: buffers decoded instructions and dispatches the head to RS or LSB.
// Define ISSUE_BUFFER_BYPASS_EN to let an instruction arriving at an empty buffer dispatch in the same cycle.
// Opcode map: 1 lui, 2 auipc, 3 jal, 4 jalr, 5-10 branch, 11-15 load, 16-18 store,
// 19-27 ALU-immediate, 28-37 ALU-register; anything else is unknown. A status of all ones means ready.
module issue_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  input  logic          clear,
  issue_buffer_if.slave bus
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [DATA_W-1:0] MAXN = '1;

  localparam logic [OP_W-1:0] OP_LUI     = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL     = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BR_LO   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BR_HI   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LD_LO   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LD_HI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_ST_LO   = OP_W'(16);
  localparam logic [OP_W-1:0] OP_ST_HI   = OP_W'(18);
  localparam logic [OP_W-1:0] OP_ALUI_LO = OP_W'(19);
  localparam logic [OP_W-1:0] OP_ALUI_HI = OP_W'(27);
  localparam logic [OP_W-1:0] OP_ALUR_LO = OP_W'(28);
  localparam logic [OP_W-1:0] OP_ALUR_HI = OP_W'(37);

  typedef enum logic [3:0] {
    C_NONE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE, C_ALUI, C_ALUR
  } op_class_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } entry_t;

  function automatic op_class_t classify(input logic [OP_W-1:0] op);
    if (op == OP_LUI)                           return C_LUI;
    if (op == OP_AUIPC)                         return C_AUIPC;
    if (op == OP_JAL)                           return C_JAL;
    if (op == OP_JALR)                          return C_JALR;
    if (op >= OP_BR_LO   && op <= OP_BR_HI)     return C_BRANCH;
    if (op >= OP_LD_LO   && op <= OP_LD_HI)     return C_LOAD;
    if (op >= OP_ST_LO   && op <= OP_ST_HI)     return C_STORE;
    if (op >= OP_ALUI_LO && op <= OP_ALUI_HI)   return C_ALUI;
    if (op >= OP_ALUR_LO && op <= OP_ALUR_HI)   return C_ALUR;
    return C_NONE;
  endfunction

  function automatic logic is_mem(input op_class_t c);
    return (c == C_LOAD) || (c == C_STORE);
  endfunction

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;
  logic             empty;
  logic             fire_head;
  logic             drop;
  logic             bypass;
  logic             push;
  logic             pop;
  logic             fire;
  entry_t           head;
  entry_t           in_entry;
  entry_t           sel;
  op_class_t        head_cls;
  op_class_t        sel_cls;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == PTR_W'(0));
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_cls = classify(head.op);
  assign in_entry = '{op: bus.id_op, rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
                      imm: bus.id_imm, pc: bus.id_pc};

  assign bus.id_ready = (count < PTR_W'(DEPTH)) && !clear;

  assign fire_head = !empty && (head_cls != C_NONE) && !bus.rob_full &&
                     !(is_mem(head_cls) ? bus.lsb_full : bus.rs_full) && rdy_in && !clear;
  // Unknown opcodes are discarded without touching the ROB or either unit
  assign drop = !empty && (head_cls == C_NONE) && rdy_in && !clear;

`ifdef ISSUE_BUFFER_BYPASS_EN
  logic      live;
  op_class_t in_cls;

  assign in_cls = classify(bus.id_op);
  // live keeps the first cycle after reset release dispatch-free
  assign bypass = empty && live && bus.id_valid && !clear && rdy_in && (in_cls != C_NONE) &&
                  !bus.rob_full && !(is_mem(in_cls) ? bus.lsb_full : bus.rs_full);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      live <= 1'b0;
    end else if (rdy_in) begin
      live <= 1'b1;
    end
  end
`else
  assign bypass = 1'b0;
`endif

  assign pop     = fire_head || drop;
  assign push    = bus.id_valid && bus.id_ready && rdy_in && !bypass;
  assign fire    = fire_head || bypass;
  assign sel     = fire_head ? head : in_entry;
  assign sel_cls = classify(sel.op);

  // FIFO storage and pointers; clear outranks push/pop
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (rdy_in) begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= in_entry;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Dispatch payload, zero whenever nothing fires
  always_comb begin
    bus.rf_rs1_addr = '0;
    bus.rf_rs2_addr = '0;
    bus.rob_valid   = 1'b0;
    bus.rob_op      = '0;
    bus.rob_pc      = '0;
    bus.rob_imm     = '0;
    bus.rob_rd      = '0;
    bus.ren_we      = 1'b0;
    bus.ren_addr    = '0;
    bus.ren_tag     = TAG_W'(0);
    bus.rs_valid    = 1'b0;
    bus.lsb_valid   = 1'b0;
    bus.q_op        = '0;
    bus.q_stat1     = '0;
    bus.q_data1     = '0;
    bus.q_stat2     = '0;
    bus.q_data2     = '0;
    bus.q_imm       = '0;
    bus.q_tag       = TAG_W'(0);

    if (!empty) begin
      bus.rf_rs1_addr = head.rs1;
      bus.rf_rs2_addr = head.rs2;
    end
`ifdef ISSUE_BUFFER_BYPASS_EN
    else begin
      bus.rf_rs1_addr = bus.id_rs1;
      bus.rf_rs2_addr = bus.id_rs2;
    end
`endif

    if (fire) begin
      bus.rob_valid = 1'b1;
      bus.rs_valid  = !is_mem(sel_cls);
      bus.lsb_valid = is_mem(sel_cls);
      bus.rob_op    = sel.op;
      bus.rob_pc    = sel.pc;
      bus.rob_imm   = sel.imm;
      bus.rob_rd    = sel.rd;
      bus.q_op      = sel.op;
      bus.q_imm     = sel.imm;
      bus.q_tag     = bus.rob_tag;
      bus.q_stat1   = bus.rf_stat1;
      bus.q_data1   = bus.rf_data1;
      bus.q_stat2   = bus.rf_stat2;
      bus.q_data2   = bus.rf_data2;
      case (sel_cls)
        C_LUI: begin
          bus.q_stat1 = MAXN;
          bus.q_data1 = '0;
          bus.q_stat2 = MAXN;
          bus.q_data2 = sel.imm;
        end
        C_AUIPC: begin
          bus.q_stat1 = MAXN;
          bus.q_data1 = sel.pc;
          bus.q_stat2 = MAXN;
          bus.q_data2 = sel.imm;
        end
        C_JAL: begin
          bus.q_stat1 = MAXN;
          bus.q_data1 = sel.pc;
          bus.q_stat2 = MAXN;
          bus.q_data2 = DATA_W'(4);
        end
        C_JALR, C_LOAD, C_ALUI: begin
          bus.q_stat2 = MAXN;
          bus.q_data2 = sel.imm;
        end
        default: ;
      endcase
      if ((sel_cls != C_BRANCH) && (sel_cls != C_STORE) && (sel.rd != REG_W'(0))) begin
        bus.ren_we   = 1'b1;
        bus.ren_addr = sel.rd;
        bus.ren_tag  = bus.rob_tag;
      end
    end
  end
endmodule

// File: tb/tb_issue_buffer.sv
// Bench for issue_buffer: directed scenarios plus random traffic against a queue-based model.
// Opcode map used: 1 lui, 2 auipc, 3 jal, 4 jalr, 5-10 branch, 11-15 load, 16-18 store, 19-27 ALU-imm, 28-37 ALU-reg.
module tb_issue_buffer;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic [DATA_W-1:0] MAXN = '1;

  typedef struct {
    logic [5:0]        op;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } instr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b0;
  logic clr   = 1'b0;

  issue_buffer_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

  issue_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .clear    (clr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  instr_t q[$];
  instr_t e_inc;
  bit     e_fire_h;
  bit     e_drop;
  bit     e_bypass;
  bit     e_push;
`ifdef ISSUE_BUFFER_BYPASS_EN
  bit     live;
`endif
  int     n_checks = 0;
  int     n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // 0 unknown, 1 lui, 2 auipc, 3 jal, 4 jalr, 5 branch, 6 load, 7 store, 8 alu-imm, 9 alu-reg
  function automatic int kind(input logic [5:0] op);
    int v;
    v = int'(op);
    if (v >= 1 && v <= 4) return v;
    if (v >= 5 && v <= 10) return 5;
    if (v >= 11 && v <= 15) return 6;
    if (v >= 16 && v <= 18) return 7;
    if (v >= 19 && v <= 27) return 8;
    if (v >= 28 && v <= 37) return 9;
    return 0;
  endfunction

  function automatic bit is_mem(input int k);
    return (k == 6) || (k == 7);
  endfunction

  function automatic bit busy(input int k);
    return is_mem(k) ? bus.lsb_full : bus.rs_full;
  endfunction

  task automatic set_idle();
    bus.id_valid = 1'b0; bus.id_op = '0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_imm = '0; bus.id_pc = '0;
    bus.rf_stat1 = '0; bus.rf_data1 = '0; bus.rf_stat2 = '0; bus.rf_data2 = '0;
    bus.rob_full = 1'b0; bus.rob_tag = '0; bus.rs_full = 1'b0; bus.lsb_full = 1'b0;
    rdy = 1'b1; clr = 1'b0;
  endtask

  task automatic set_instr(input int op, input int rs1, input int rs2, input int rd,
                           input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc);
    bus.id_valid = 1'b1; bus.id_op = 6'(op); bus.id_rs1 = 5'(rs1); bus.id_rs2 = 5'(rs2);
    bus.id_rd = 5'(rd); bus.id_imm = imm; bus.id_pc = pc;
  endtask

  // Compare every output against the model for the inputs currently applied
  task automatic eval();
    instr_t s;
    int kh, ks;
    bit firing, wr;
    logic [DATA_W-1:0] o1s, o1d, o2s, o2d;
    logic [4:0] a1, a2;
    #1;
    e_inc = '{op: bus.id_op, rs1: bus.id_rs1, rs2: bus.id_rs2, rd: bus.id_rd,
              imm: bus.id_imm, pc: bus.id_pc};
    kh = (q.size() > 0) ? kind(q[0].op) : 0;
    e_fire_h = (q.size() > 0) && (kh != 0) && !bus.rob_full && !busy(kh) && rdy && !clr;
    e_drop   = (q.size() > 0) && (kh == 0) && rdy && !clr;
    e_bypass = 1'b0;
    a1 = 5'd0;
    a2 = 5'd0;
`ifdef ISSUE_BUFFER_BYPASS_EN
    e_bypass = (q.size() == 0) && live && bus.id_valid && !clr && rdy && (kind(bus.id_op) != 0) &&
               !bus.rob_full && !busy(kind(bus.id_op));
    a1 = bus.id_rs1;
    a2 = bus.id_rs2;
`endif
    if (q.size() > 0) begin
      a1 = q[0].rs1;
      a2 = q[0].rs2;
    end
    e_push = bus.id_valid && (q.size() < DEPTH) && !clr && rdy && !e_bypass;
    firing = e_fire_h || e_bypass;
    s  = e_fire_h ? q[0] : e_inc;
    ks = kind(s.op);
    o1s = bus.rf_stat1; o1d = bus.rf_data1; o2s = bus.rf_stat2; o2d = bus.rf_data2;
    case (ks)
      1: begin o1s = MAXN; o1d = '0;   o2s = MAXN; o2d = s.imm; end
      2: begin o1s = MAXN; o1d = s.pc; o2s = MAXN; o2d = s.imm; end
      3: begin o1s = MAXN; o1d = s.pc; o2s = MAXN; o2d = 32'd4; end
      4, 6, 8: begin o2s = MAXN; o2d = s.imm; end
      default: ;
    endcase
    if (!firing) begin
      o1s = '0; o1d = '0; o2s = '0; o2d = '0;
    end
    wr = firing && (ks != 5) && (ks != 7) && (s.rd != 5'd0);

    check_eq("id_ready",  64'(bus.id_ready),  64'((q.size() < DEPTH) && !clr));
    check_eq("rf_rs1",    64'(bus.rf_rs1_addr), 64'(a1));
    check_eq("rf_rs2",    64'(bus.rf_rs2_addr), 64'(a2));
    check_eq("rob_valid", 64'(bus.rob_valid), 64'(firing));
    check_eq("rs_valid",  64'(bus.rs_valid),  64'(firing && !is_mem(ks)));
    check_eq("lsb_valid", 64'(bus.lsb_valid), 64'(firing && is_mem(ks)));
    check_eq("rob_op",    64'(bus.rob_op),    firing ? 64'(s.op)  : 64'(0));
    check_eq("rob_pc",    64'(bus.rob_pc),    firing ? 64'(s.pc)  : 64'(0));
    check_eq("rob_imm",   64'(bus.rob_imm),   firing ? 64'(s.imm) : 64'(0));
    check_eq("rob_rd",    64'(bus.rob_rd),    firing ? 64'(s.rd)  : 64'(0));
    check_eq("ren_we",    64'(bus.ren_we),    64'(wr));
    check_eq("ren_addr",  64'(bus.ren_addr),  wr ? 64'(s.rd) : 64'(0));
    check_eq("ren_tag",   64'(bus.ren_tag),   wr ? 64'(bus.rob_tag) : 64'(0));
    check_eq("q_op",      64'(bus.q_op),      firing ? 64'(s.op)  : 64'(0));
    check_eq("q_imm",     64'(bus.q_imm),     firing ? 64'(s.imm) : 64'(0));
    check_eq("q_tag",     64'(bus.q_tag),     firing ? 64'(bus.rob_tag) : 64'(0));
    check_eq("q_stat1",   64'(bus.q_stat1),   64'(o1s));
    check_eq("q_data1",   64'(bus.q_data1),   64'(o1d));
    check_eq("q_stat2",   64'(bus.q_stat2),   64'(o2s));
    check_eq("q_data2",   64'(bus.q_data2),   64'(o2d));
  endtask

  task automatic adv();
    @(posedge clk);
    if (clr) q.delete();
    else if (rdy) begin
      if (e_fire_h || e_drop) void'(q.pop_front());
      if (e_push) q.push_back(e_inc);
    end
`ifdef ISSUE_BUFFER_BYPASS_EN
    if (rdy) live = 1'b1;
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_idle();
    q.delete();
`ifdef ISSUE_BUFFER_BYPASS_EN
    live = 1'b0;
`endif
    #1;
    check_eq("rst_rob_valid", 64'(bus.rob_valid), 64'(0));
    check_eq("rst_rs_valid",  64'(bus.rs_valid),  64'(0));
    check_eq("rst_lsb_valid", 64'(bus.lsb_valid), 64'(0));
    check_eq("rst_ren_we",    64'(bus.ren_we),    64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leaves the cycle in which the just-driven instruction dispatches evaluated
  task automatic dispatch_cycle();
    eval();
`ifndef ISSUE_BUFFER_BYPASS_EN
    adv();
    bus.id_valid = 1'b0;
    eval();
`endif
  endtask

  initial begin
    int r;
    do_reset();
    set_idle();
    eval(); adv();

    // add x3,x1,x2 with ready operands, ROB tag 7
    set_instr(28, 1, 2, 3, 32'h0, 32'h100);
    bus.rf_stat1 = MAXN; bus.rf_stat2 = MAXN; bus.rob_tag = 5'd7;
    dispatch_cycle();
    check_eq("add_rs_valid",  64'(bus.rs_valid),  64'(1));
    check_eq("add_rob_valid", 64'(bus.rob_valid), 64'(1));
    check_eq("add_ren_we",    64'(bus.ren_we),    64'(1));
    check_eq("add_ren_addr",  64'(bus.ren_addr),  64'(3));
    check_eq("add_ren_tag",   64'(bus.ren_tag),   64'(7));
    adv();
    set_idle();

    // addi x0,x1,5: immediate operand, no rename
    set_instr(19, 1, 0, 0, 32'd5, 32'h104);
    dispatch_cycle();
    check_eq("addi_rs_valid", 64'(bus.rs_valid), 64'(1));
    check_eq("addi_stat2",    64'(bus.q_stat2),  64'(MAXN));
    check_eq("addi_data2",    64'(bus.q_data2),  64'(5));
    check_eq("addi_ren_we",   64'(bus.ren_we),   64'(0));
    adv();
    set_idle();

    // DEPTH loads against a full LSB, then drain in order
    bus.lsb_full = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      set_instr(13, i, 0, i + 1, 32'(4 * i), 32'(32'h200 + 4 * i));
      eval(); adv();
    end
    set_instr(13, 9, 0, 9, 32'h0, 32'h300);
    eval();
    check_eq("full_id_ready", 64'(bus.id_ready), 64'(0));
    adv();
    bus.id_valid = 1'b0; bus.lsb_full = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      eval();
      check_eq("drain_lsb_valid", 64'(bus.lsb_valid), 64'(1));
      check_eq("drain_pc",        64'(bus.rob_pc),    64'(32'h200 + 4 * i));
      if (i == 1) check_eq("drain_id_ready", 64'(bus.id_ready), 64'(1));
      adv();
    end

    // Flush with three entries held and a push attempted in the clear cycle
    bus.rob_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(29, i, i + 1, i + 2, 32'h0, 32'(32'h280 + 4 * i));
      eval(); adv();
    end
    bus.rob_full = 1'b0; clr = 1'b1;
    set_instr(30, 4, 5, 6, 32'h0, 32'h2c0);
    eval();
    check_eq("clr_rob_valid", 64'(bus.rob_valid), 64'(0));
    check_eq("clr_id_ready",  64'(bus.id_ready),  64'(0));
    adv();
    clr = 1'b0; bus.id_valid = 1'b0;
    eval();
    check_eq("post_clr_valid", 64'(bus.rob_valid), 64'(0));
    adv();

    // Simultaneous push and pop across pointer wrap
    bus.rob_full = 1'b1;
    set_instr(31, 1, 2, 3, 32'h0, 32'h3fc);
    eval(); adv();
    bus.rob_full = 1'b0;
    for (int i = 0; i < int'(2 * DEPTH + 1); i++) begin
      set_instr(31, i, i + 1, i + 2, 32'(i), 32'(32'h400 + 4 * i));
      eval();
      check_eq("wrap_id_ready", 64'(bus.id_ready), 64'(1));
      check_eq("wrap_pc",       64'(bus.rob_pc),   64'(32'h3fc + 4 * i));
      adv();
    end
    bus.id_valid = 1'b0;
    eval(); adv();

    // rdy_in low freezes the buffer
    bus.rob_full = 1'b1;
    set_instr(20, 1, 0, 2, 32'h1, 32'h500); eval(); adv();
    set_instr(21, 1, 0, 2, 32'h2, 32'h504); eval(); adv();
    bus.rob_full = 1'b0; bus.id_valid = 1'b0; rdy = 1'b0;
    repeat (3) begin
      eval();
      check_eq("stall_rob_valid", 64'(bus.rob_valid), 64'(0));
      adv();
    end
    rdy = 1'b1;
    eval(); check_eq("resume_pc0", 64'(bus.rob_pc), 64'(32'h500)); adv();
    eval(); check_eq("resume_pc1", 64'(bus.rob_pc), 64'(32'h504)); adv();

    // Reset mid-operation discards entries; nothing dispatches in the first cycle
    bus.rob_full = 1'b1;
    set_instr(28, 1, 2, 3, 32'h0, 32'h600); eval(); adv();
    set_instr(28, 1, 2, 4, 32'h0, 32'h604); eval(); adv();
    bus.rob_full = 1'b0;
    eval();
    #2;
    do_reset();
    set_instr(28, 5, 6, 7, 32'h0, 32'h700);
    eval();
    check_eq("rel_rob_valid", 64'(bus.rob_valid), 64'(0));
    adv();
    bus.id_valid = 1'b0;
    eval(); adv();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      bus.id_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) begin
        r = int'($urandom_range(37, 63));
        bus.id_op = (r == 37) ? 6'd0 : 6'(r);
      end else begin
        bus.id_op = 6'($urandom_range(1, 37));
      end
      bus.id_rs1 = 5'($urandom_range(0, 31));
      bus.id_rs2 = 5'($urandom_range(0, 31));
      bus.id_rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.id_imm = $urandom;
      bus.id_pc  = $urandom;
      bus.rf_stat1 = ($urandom_range(0, 1) == 0) ? MAXN : 32'($urandom_range(0, 31));
      bus.rf_stat2 = ($urandom_range(0, 1) == 0) ? MAXN : 32'($urandom_range(0, 31));
      bus.rf_data1 = $urandom;
      bus.rf_data2 = $urandom;
      bus.rob_full = ($urandom_range(0, 4) == 0);
      bus.rob_tag  = TAG_W'($urandom_range(0, 31));
      bus.rs_full  = ($urandom_range(0, 3) == 0);
      bus.lsb_full = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 24) == 0);
      eval(); adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/issue_buffer.md
ISSUE_BUFFER -- requirements
Module: issue_buffer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  DEPTH 4: entries, power of two, 2..16.
  TAG_W 5: ROB tag width.
  DATA_W 32: data/pc/imm width.
REQ-002 Ports (name direction width meaning) SHALL be:
  clk_in  in  1  clock.
  rst_n_in  in  1  reset.
  rdy_in  in  1  global enable; low freezes all state.
  clear  in  1  flush (branch mispredict).
  id_valid  in  1  decoded instruction present.
  id_ready  out  1  buffer can accept.
  id_op  in  6  opcode; id_rs1 / id_rs2 / id_rd  in  5  register indices; id_imm / id_pc  in  DATA_W.
  rf_rs1_addr / rf_rs2_addr  out  5  head source indices.
  rf_stat1 / rf_data1 / rf_stat2 / rf_data2  in  DATA_W  rename tag (`MAXN = ready) and value.
  rob_full  in  1; rob_tag  in  TAG_W  next free ROB tag; rob_valid  out  1; rob_op  out  6; rob_pc / rob_imm  out  DATA_W; rob_rd  out  5.
  ren_we  out  1; ren_addr  out  5; ren_tag  out  TAG_W  rename write.
  rs_full / lsb_full  in  1; rs_valid / lsb_valid  out  1.
  q_op  out  6; q_stat1 / q_data1 / q_stat2 / q_data2 / q_imm  out  DATA_W; q_tag  out  TAG_W  shared payload for RS and LSB.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.

Function
REQ-004 Buffer SHALL be a circular FIFO of DEPTH entries {op, rs1, rs2, rd, imm, pc}; pointers one bit wider than log2(DEPTH), wrap modulo DEPTH.
REQ-005 id_ready SHALL equal (count < DEPTH) && !clear; push when id_valid && id_ready && rdy_in.
REQ-006 Head route: loads/stores -> LSB; all other opcodes -> RS; fire = !empty && !rob_full && !(target unit full) && rdy_in && !clear.
REQ-007 On fire, rob_valid and exactly one of rs_valid/lsb_valid SHALL assert for that cycle and the head SHALL pop; at most one dispatch per cycle.
REQ-008 Push and pop in the same cycle SHALL leave count unchanged; push when full SHALL be impossible (id_ready low) even if a pop occurs that cycle.
REQ-009 Operands: R-type, branches, stores pass register status/data for rs1 and rs2; I-type ALU, loads, jalr: operand 2 = {`MAXN, imm}; jal/auipc: operand 1 = {`MAXN, pc}, operand 2 = {`MAXN, 4 (jal) or imm (auipc)}; lui: operand 1 = {`MAXN, 0}, operand 2 = {`MAXN, imm}.
REQ-010 ren_we SHALL assert on fire for rd-writing opcodes (all but branches and stores) only when rd != 0, with ren_addr = rd, ren_tag = rob_tag; q_tag = rob_tag.
REQ-011 When not firing, all valid/we outputs SHALL be 0 and all payload outputs SHALL be 0.
REQ-012 clear SHALL empty the FIFO at the next edge, suppress dispatch and push in the clear cycle; clear wins over simultaneous push/pop.
REQ-013 rdy_in low SHALL hold pointers and contents and force all valid outputs 0.
REQ-014 Unknown opcodes at the head SHALL be popped and dropped without any valid output asserted (needs only !empty && rdy_in && !clear).

Reset
REQ-015 rst_n_in low SHALL asynchronously zero pointers, count and all entries; all outputs SHALL be 0 except id_ready = 1 once released.
REQ-016 Reset mid-operation SHALL discard all entries; no dispatch in the first cycle after release.

Configuration
REQ-017 Macro ISSUE_BUFFER_BYPASS_EN: defined -> when the FIFO is empty and the instruction on id_* can fire, it SHALL dispatch in the same cycle without being written (0-cycle latency); undefined -> every instruction SHALL be written first, minimum latency push-to-dispatch 1 cycle.

Verification
REQ-018 Reset, push add x3,x1,x2 with rf_stat1 = rf_stat2 = `MAXN, rob_tag = 7 -> next cycle rs_valid = rob_valid = ren_we = 1, ren_addr = 3, ren_tag = 7 (same cycle with bypass).
REQ-019 Push DEPTH lw with lsb_full = 1 -> id_ready = 0 after DEPTH pushes; release lsb_full -> one lsb_valid per cycle, in order, id_ready returns 1 after first pop.
REQ-020 addi x0,x1,5 -> rs_valid = 1, q_stat2 = `MAXN, q_data2 = 5, ren_we = 0.
REQ-021 Fill 3 entries, assert clear with id_valid = 1 -> no dispatch that cycle, buffer empty next cycle, pushed instruction discarded.
REQ-022 Push/pop simultaneously across 2*DEPTH+1 instructions -> pointers wrap, order preserved, count stable.
REQ-023 rdy_in = 0 for 3 cycles with rob_full = 0 -> no valid outputs, contents unchanged; dispatch resumes when rdy_in = 1.
